// File: rtl/ripemd160_pkg.sv
// ripemd160_pkg: shared widths, padder states and constants for the RIPEMD-160 datapath
package ripemd160_pkg;
  localparam int BLK_W = 512;
  localparam int WORD_W = 32;
  localparam int LEN_OFF = 448;
  localparam int LAST_DATA = 55;
  localparam logic [7:0] PAD_BYTE = 8'h80;
  localparam logic [159:0] H0 = {32'hC3D2E1F0, 32'h10325476, 32'h98BADCFE, 32'hEFCDAB89, 32'h67452301};
  typedef enum logic [1:0] {S_FILL, S_PAD, S_EMIT, S_EXTRA} pad_state_t;
endpackage

// File: rtl/ripemd160_pad_mask.sv
// ripemd160_pad_mask: keeps bytes below q, places 0x80 at q, zeroes the rest, inserts length if it fits
module ripemd160_pad_mask
  import ripemd160_pkg::*;
(
  input  logic [BLK_W-1:0] data,
  input  logic [6:0]       q,
  input  logic [63:0]      len,
  output logic [BLK_W-1:0] padded,
  output logic             fits
);
  // byte-wise mask, then overlay the length field when there is room for it
  always_comb begin
    fits = q <= 7'(LAST_DATA);
    padded = '0;
    for (int i = 0; i < BLK_W / 8; i++)
      padded[8*i +: 8] = (7'(i) < q) ? data[8*i +: 8] : ((7'(i) == q) ? PAD_BYTE : 8'h00);
    if (fits) padded[LEN_OFF +: 64] = len;
  end
endmodule

// File: rtl/ripemd160_msg_padder.sv
// ripemd160_msg_padder: byte stream to padded 512-bit RIPEMD-160 blocks
module ripemd160_msg_padder
  import ripemd160_pkg::*;
#(
  parameter int LEN_W = 61
) (
  input  logic             clk_p_i,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_keep,
  input  logic             in_last,
  output logic             o_valid,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] block,
  output logic             o_first,
  output logic             o_last
);
  pad_state_t       state;
  logic [5:0]       ptr;
  logic [6:0]       q;
  logic [LEN_W-1:0] byte_cnt;
  logic             pending, need80, first_flag, pm_fits;
  logic [63:0]      bit_len;
  logic [BLK_W-1:0] pm_blk;

  assign bit_len = 64'({byte_cnt, 3'b000});

  // the extra block is a padding of an empty buffer: 0x80 at byte 0 only when it did not fit earlier
  ripemd160_pad_mask u_mask (
    .data  (state == S_EXTRA ? '0 : block),
    .q     (state == S_EXTRA ? (need80 ? 7'd0 : 7'd64) : q),
    .len   (bit_len),
    .padded(pm_blk),
    .fits  (pm_fits)
  );

  // message assembly, padding and block hand-off state machine
  always_ff @(posedge clk_p_i or negedge rst_n)
    if (!rst_n) begin
      state <= S_FILL;
      ptr <= '0;
      q <= '0;
      byte_cnt <= '0;
      pending <= 1'b0;
      need80 <= 1'b0;
      first_flag <= 1'b1;
      in_ready <= 1'b1;
      o_valid <= 1'b0;
      block <= '0;
      o_first <= 1'b0;
      o_last <= 1'b0;
    end else begin
      case (state)
        S_FILL: if (in_valid) begin
          if (in_keep) begin
            block[{ptr, 3'b000} +: 8] <= in_data;
            ptr <= ptr + 6'd1;
            byte_cnt <= byte_cnt + 1'b1;
          end
          if (in_last) begin
            q <= {1'b0, ptr} + {6'd0, in_keep};
            in_ready <= 1'b0;
            state <= S_PAD;
          end else if (in_keep && &ptr) begin
            o_valid <= 1'b1;
            o_first <= first_flag;
            o_last <= 1'b0;
            in_ready <= 1'b0;
            state <= S_EMIT;
          end
        end
        S_PAD: begin
          block <= pm_blk;
          o_valid <= 1'b1;
          o_first <= first_flag;
          o_last <= pm_fits;
          pending <= !pm_fits;
          need80 <= q == 7'd64;
          state <= S_EMIT;
        end
        S_EMIT: if (blk_ready) begin
          o_valid <= 1'b0;
          first_flag <= 1'b0;
          if (pending) state <= S_EXTRA;
          else begin
            ptr <= '0;
            if (o_last) begin
              byte_cnt <= '0;
              first_flag <= 1'b1;
            end
            in_ready <= 1'b1;
            state <= S_FILL;
          end
        end
        default: begin
          block <= {bit_len, pm_blk[LEN_OFF-1:0]};
          o_valid <= 1'b1;
          o_first <= first_flag;
          o_last <= 1'b1;
          pending <= 1'b0;
          state <= S_EMIT;
        end
      endcase
    end
endmodule

// File: tb/tb_ripemd160_msg_padder.sv
// tb_ripemd160_msg_padder: scoreboard bench with directed messages and hand-computed blocks
module tb_ripemd160_msg_padder;
  logic         clk_p_i = 0, rst_n = 0, in_valid = 0, in_keep = 0, in_last = 0, blk_ready = 1;
  logic [7:0]   in_data = 0;
  logic         in_ready, o_valid, o_first, o_last;
  logic [511:0] block;
  int total = 0, bad = 0;

  typedef struct packed {logic [511:0] b; logic f; logic l;} exp_t;
  exp_t exp_q[$];

  ripemd160_msg_padder dut (
    .clk_p_i(clk_p_i), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_keep(in_keep), .in_last(in_last), .o_valid(o_valid),
    .blk_ready(blk_ready), .block(block), .o_first(o_first), .o_last(o_last)
  );

  always #5 clk_p_i = ~clk_p_i;

  task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, got, want);
    end
  endtask

  // monitor: a block is taken at the next posedge whenever o_valid && blk_ready here
  always @(negedge clk_p_i)
    if (rst_n && o_valid && blk_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_block got=%h", block);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("blk_data", block, e.b);
        chk("blk_first", 512'(o_first), 512'(e.f));
        chk("blk_last", 512'(o_last), 512'(e.l));
      end
    end

  task automatic push(input logic [511:0] b, input logic f, input logic l);
    exp_t e;
    e.b = b;
    e.f = f;
    e.l = l;
    exp_q.push_back(e);
  endtask

  task automatic xfer(input logic [7:0] d, input logic k, input logic l);
    int n = 0;
    in_valid = 1;
    in_data = d;
    in_keep = k;
    in_last = l;
    @(negedge clk_p_i);
    while (!in_ready && n < 300) begin
      n++;
      @(negedge clk_p_i);
    end
    if (!in_ready) begin
      total++;
      bad++;
      $display("FAIL xfer_timeout got=in_ready0 want=in_ready1");
    end
    @(posedge clk_p_i);
    #1 in_valid = 0;
  endtask

  task automatic send_msg(input int n, input logic [7:0] base, input bit inc, input bit last);
    for (int i = 0; i < n; i++)
      xfer(base + (inc ? 8'(i) : 8'd0), 1'b1, last && i == n - 1);
  endtask

  task automatic wait_idle;
    int n = 0;
    @(negedge clk_p_i);
    while ((exp_q.size() != 0 || !in_ready || o_valid) && n < 500) begin
      n++;
      @(negedge clk_p_i);
    end
    if (n >= 500) begin
      total++;
      bad++;
      $display("FAIL idle_timeout got=busy want=idle");
    end
    @(posedge clk_p_i);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [511:0] abc, b;
    abc = '0;
    abc[31:0] = 32'h80636261;
    abc[479:448] = 32'h18;
    #3;
    chk("rst_valid", 512'(o_valid), 0);
    chk("rst_block", block, 0);
    chk("rst_first_last", 512'({o_first, o_last}), 0);
    @(posedge clk_p_i);
    #1 rst_n = 1;
    #1 chk("rst_in_ready", 512'(in_ready), 1);
    @(posedge clk_p_i);
    #1;
    // empty message
    b = '0;
    b[31:0] = 32'h80;
    push(b, 1, 1);
    xfer(8'h00, 1'b0, 1'b1);
    wait_idle();
    // "abc" with latency check
    push(abc, 1, 1);
    send_msg(3, 8'h61, 1, 1);
    @(negedge clk_p_i);
    chk("abc_lat_t1", 512'(o_valid), 0);
    @(negedge clk_p_i);
    chk("abc_lat_t2", 512'(o_valid), 1);
    wait_idle();
    // 55 zero bytes: last that fits in one block
    b = '0;
    b[447:440] = 8'h80;
    b[511:448] = 64'h1B8;
    push(b, 1, 1);
    send_msg(55, 8'h00, 0, 1);
    wait_idle();
    // 56 zero bytes: length spills into a second block
    b = '0;
    b[455:448] = 8'h80;
    push(b, 1, 0);
    b = '0;
    b[511:448] = 64'h1C0;
    push(b, 0, 1);
    send_msg(56, 8'h00, 0, 1);
    wait_idle();
    // 64 bytes 0..63: pure data block, then 0x80 and length
    for (int i = 0; i < 64; i++) b[8*i +: 8] = 8'(i);
    push(b, 1, 0);
    b = '0;
    b[7:0] = 8'h80;
    b[511:448] = 64'h200;
    push(b, 0, 1);
    send_msg(64, 8'h00, 1, 1);
    wait_idle();
    // back-pressure: block held stable for 10 cycles
    blk_ready = 0;
    push(abc, 1, 1);
    send_msg(3, 8'h61, 1, 1);
    begin
      int n = 0;
      @(negedge clk_p_i);
      while (!o_valid && n < 20) begin
        n++;
        @(negedge clk_p_i);
      end
    end
    for (int i = 0; i < 10; i++) begin
      chk("stall_valid", 512'(o_valid), 1);
      chk("stall_block", block, abc);
      chk("stall_fl", 512'({o_first, o_last, in_ready}), 512'(3'b110));
      @(negedge clk_p_i);
    end
    @(posedge clk_p_i);
    #1 blk_ready = 1;
    wait_idle();
    chk("post_stall_in_ready", 512'(in_ready), 1);
    // reset mid-message, then a clean "abc"
    send_msg(20, 8'h11, 0, 0);
    rst_n = 0;
    #2;
    chk("midrst_valid", 512'(o_valid), 0);
    chk("midrst_block", block, 0);
    chk("midrst_first_last", 512'({o_first, o_last}), 0);
    @(posedge clk_p_i);
    @(posedge clk_p_i);
    #1 rst_n = 1;
    @(posedge clk_p_i);
    #1;
    push(abc, 1, 1);
    send_msg(3, 8'h61, 1, 1);
    wait_idle();
    chk("queue_empty", 512'(exp_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
